// File: rtl/q_sys_pio_edge.sv
// Memory-mapped parallel I/O port: registered outputs with set/clear aliases, synchronised inputs,
// per-bit edge capture with write-1-to-clear and a masked level interrupt. Zero-wait writes, 0-latency reads.
module q_sys_pio_edge #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_OUTSET  = 3'd1;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd2;
  localparam logic [2:0] ADDR_IRQMASK = 3'd3;
  localparam logic [2:0] ADDR_EDGECAP = 3'd4;
  localparam logic [2:0] ADDR_OUTRB   = 3'd5;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] s1_q, s2_q, prev_q;
  logic [1:0]       arm_q, arm_d;

  logic             wr_en;
  logic             armed;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] edge_det;
  logic             unused_wdat;

  assign wr_en       = chipselect & ~write_n;
  assign wdat        = writedata[WIDTH-1:0];
  assign unused_wdat = ^writedata;
  assign armed       = (arm_q == 2'd3);

  always_comb begin
    if (EDGE_TYPE == 0) begin
      edge_det = s2_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~s2_q & prev_q;
    end else begin
      edge_det = s2_q ^ prev_q;
    end
  end

  always_comb begin
    out_d   = out_q;
    mask_d  = mask_q;
    cap_clr = '0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:    out_d   = wdat;
        ADDR_OUTSET:  out_d   = out_q | wdat;
        ADDR_OUTCLR:  out_d   = out_q & ~wdat;
        ADDR_IRQMASK: mask_d  = wdat;
        ADDR_EDGECAP: cap_clr = wdat;
        default:      ;
      endcase
    end
    // A fresh edge overrides a simultaneous clear so no event is ever lost.
    cap_d = (cap_q & ~cap_clr) | (edge_det & {WIDTH{armed}});
    arm_d = armed ? arm_q : arm_q + 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= RESET_VALUE;
      mask_q <= '0;
      cap_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      arm_q  <= 2'd0;
    end else begin
      out_q  <= out_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      s1_q   <= in_port;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      arm_q  <= arm_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = s2_q;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = cap_q;
      ADDR_OUTRB:   readdata[WIDTH-1:0] = out_q;
      default:      ;
    endcase
  end

  assign out_port = out_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: doc/q_sys_pio_edge.md
Q_SYS_PIO_EDGE -- requirements
Module: q_sys_pio_edge

Interface
REQ-001 SHALL have parameter WIDTH, default 8, port width in bits, legal range 1..32.
REQ-002 SHALL have parameter RESET_VALUE, default 0, reset value of the output register (WIDTH bits).
REQ-003 SHALL have parameter EDGE_TYPE, default 0, edge to capture: 0 rising, 1 falling, 2 any.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port address, input, 3, register select.
REQ-007 SHALL have port chipselect, input, 1, slave select.
REQ-008 SHALL have port write_n, input, 1, active-low write strobe.
REQ-009 SHALL have port writedata, input, 32, write data; bits above WIDTH-1 ignored.
REQ-010 SHALL have port readdata, output, 32, read data; bits above WIDTH-1 driven 0.
REQ-011 SHALL have port in_port, input, WIDTH, asynchronous external inputs.
REQ-012 SHALL have port out_port, output, WIDTH, registered outputs.
REQ-013 SHALL have port irq, output, 1, level interrupt.

Function
REQ-014 SHALL perform a write only in a cycle with chipselect=1 and write_n=0; zero wait states.
REQ-015 SHALL drive readdata combinationally from address and current register state (read latency 0), independent of chipselect.
REQ-016 SHALL map address 0 DATA: read = synchronised in_port; write loads out register.
REQ-017 SHALL map address 1 OUTSET: write sets each out bit whose writedata bit is 1; reads 0.
REQ-018 SHALL map address 2 OUTCLR: write clears each out bit whose writedata bit is 1; reads 0.
REQ-019 SHALL map address 3 IRQMASK: read/write WIDTH-bit mask.
REQ-020 SHALL map address 4 EDGECAP: read capture bits; write-1-to-clear per bit.
REQ-021 SHALL map address 5 OUTRB: read returns out register; writes ignored.
REQ-022 SHALL return 0 for reads of addresses 6-7 and ignore writes to them.
REQ-023 SHALL drive out_port directly from the out register.
REQ-024 SHALL synchronise in_port through two flops (s1, s2) plus a history flop (prev = previous s2).
REQ-025 SHALL define edge per bit as s2&~prev (EDGE_TYPE 0), ~s2&prev (1), s2^prev (2).
REQ-026 SHALL set an EDGECAP bit on the clock edge following a detected edge; bit stays set until cleared.
REQ-027 SHALL, when an edge and a write-1-to-clear hit the same bit in the same cycle, leave the bit set (set wins).
REQ-028 SHALL drive irq = OR over (EDGECAP & IRQMASK), combinational from registers.
REQ-029 SHALL give latency: in_port change sampled at clock k -> visible on DATA read after k+1 -> EDGECAP and irq set after k+2.
REQ-030 SHALL hold a 2-bit arm counter, saturating at 3, incrementing each clock after reset; edge capture enabled only while counter=3.
REQ-031 SHALL drop (not capture) edges occurring while the arm counter is below 3, so static inputs at reset never cause captures.
REQ-032 SHALL not clear EDGECAP on IRQMASK writes; unmasking a set bit asserts irq immediately.

Reset
REQ-033 SHALL on reset asynchronously force out register to RESET_VALUE, s1/s2/prev to 0, EDGECAP to 0, IRQMASK to 0, arm counter to 0.
REQ-034 SHALL hold irq=0 and out_port=RESET_VALUE while reset is high; reset mid-write discards the write.

Verification
REQ-035 SHALL verify: write 0xA5 to addr 0, then 0x0F to addr 1, then 0x81 to addr 2 -> out_port 0xA5, 0xAF, 0x2E; OUTRB reads match.
REQ-036 SHALL verify: EDGE_TYPE 0, IRQMASK=0x01, in_port bit0 0->1 at clock k -> DATA bit0=1 after k+1, EDGECAP=0x01 and irq=1 after k+2.
REQ-037 SHALL verify: write 0x01 to addr 4 same cycle as new edge on bit0 -> EDGECAP bit0 remains 1; next clear without edge -> 0, irq=0.
REQ-038 SHALL verify: in_port=0xFF held through reset release, IRQMASK=0xFF -> EDGECAP stays 0x00, irq=0 for 20 clocks.
REQ-039 SHALL verify: EDGE_TYPE 2, WIDTH 1, pulse 1-0 on in_port -> EDGECAP set after each edge; readdata[31:1]=0 on every address.
REQ-040 SHALL verify: assert reset mid-operation with EDGECAP=0x03, out=0x55, RESET_VALUE=0x3C -> immediately EDGECAP 0, out_port 0x3C, irq 0.
